// File: rtl/axi_rd_burst_split.sv
// ---------------------------------------------------------------------------
// axi_rd_burst_split
//
// AXI4 read-channel stage between an upstream master (s_*) and memory (mem_*).
// Long INCR bursts are cut into sub-bursts of at most MaxBeats beats. FIXED
// and WRAP bursts pass through whole. An in-flight FIFO holds one entry per
// issued sub-burst: {id, final-sub-burst flag}. The R channel is a
// combinational pass-through, except that s_r_last is only raised on the
// last beat of the final sub-burst of each upstream burst.
//
// New ARs are only accepted while the FIFO is empty, or when they carry the
// same id as the most recently issued sub-burst. This keeps R beats of
// different ids from interleaving behind the FIFO head.
//
// Optional feature macro: AXI_RD_SPLIT_4K_EN
//   When defined, INCR sub-bursts are also cut at 4 KiB address boundaries.
//
// Ports
//   clk, rstn                      clock, async active-low reset
//   s_ar_*   (in), s_ar_ready      upstream AR channel
//   mem_ar_* (out), mem_ar_ready   downstream AR channel
//   mem_r_*  (in), mem_r_ready     downstream R channel
//   s_r_*    (out), s_r_ready      upstream R channel
//
// State  | meaning
// IDLE   | AR register empty, may accept an upstream AR
// ISSUE  | AR register holds a pending burst or its remainder
// ---------------------------------------------------------------------------
module axi_rd_burst_split #(
    parameter int unsigned IdWidth     = 1,
    parameter int unsigned AddrWidth   = 56,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned MaxBeats    = 16,
    parameter int unsigned Outstanding = 4
) (
    input  logic                 clk,
    input  logic                 rstn,

    input  logic [IdWidth-1:0]   s_ar_id,
    input  logic [AddrWidth-1:0] s_ar_addr,
    input  logic [7:0]           s_ar_len,
    input  logic [2:0]           s_ar_size,
    input  logic [1:0]           s_ar_burst,
    input  logic                 s_ar_valid,
    output logic                 s_ar_ready,

    output logic [IdWidth-1:0]   mem_ar_id,
    output logic [AddrWidth-1:0] mem_ar_addr,
    output logic [7:0]           mem_ar_len,
    output logic [2:0]           mem_ar_size,
    output logic [1:0]           mem_ar_burst,
    output logic                 mem_ar_valid,
    input  logic                 mem_ar_ready,

    input  logic [IdWidth-1:0]   mem_r_id,
    input  logic [DataWidth-1:0] mem_r_data,
    input  logic [1:0]           mem_r_resp,
    input  logic                 mem_r_last,
    input  logic                 mem_r_valid,
    output logic                 mem_r_ready,

    output logic [IdWidth-1:0]   s_r_id,
    output logic [DataWidth-1:0] s_r_data,
    output logic [1:0]           s_r_resp,
    output logic                 s_r_last,
    output logic                 s_r_valid,
    input  logic                 s_r_ready
);

    localparam int unsigned PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
    localparam int unsigned CntW = $clog2(Outstanding + 1);
    localparam logic [1:0]  BurstIncr = 2'b01;

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e               state_q;
    logic                 rdy_en_q;
    logic [IdWidth-1:0]   ar_id_q;
    logic [AddrWidth-1:0] ar_addr_q;
    logic [2:0]           ar_size_q;
    logic [1:0]           ar_burst_q;
    logic [8:0]           remain_q;

    logic [Outstanding-1:0] fifo_flag_q;
    logic [IdWidth-1:0]     fifo_id_q [Outstanding];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic                 fifo_full, fifo_empty;
    logic                 push, pop, last_sub, head_flag;
    logic [PtrW-1:0]      tail_ptr;
    logic [IdWidth-1:0]   tail_id;
    logic [8:0]           beats;
    logic [8:0]           remain_d;
    logic [AddrWidth-1:0] addr_d;

    // ------------------------------------------------------------------
    // Sub-burst size
    // ------------------------------------------------------------------
`ifdef AXI_RD_SPLIT_4K_EN
    logic [12:0] page_room;
    logic [12:0] page_beats;
`endif

    always_comb begin
        beats = remain_q;
`ifdef AXI_RD_SPLIT_4K_EN
        page_room  = 13'd4096 - {1'b0, ar_addr_q[11:0]};
        page_beats = page_room >> ar_size_q;
        // An unaligned start within the last beat of a page still has to
        // move at least one beat forward.
        if (page_beats == 13'd0) begin
            page_beats = 13'd1;
        end
`endif
        if (ar_burst_q == BurstIncr) begin
            if (remain_q > 9'(MaxBeats)) begin
                beats = 9'(MaxBeats);
            end
`ifdef AXI_RD_SPLIT_4K_EN
            if (page_beats < {4'd0, beats}) begin
                beats = page_beats[8:0];
            end
`endif
        end
    end

    assign remain_d = remain_q - beats;
    assign addr_d   = ar_addr_q + (AddrWidth'(beats) << ar_size_q);
    assign last_sub = (remain_d == 9'd0);

    // ------------------------------------------------------------------
    // In-flight FIFO
    // ------------------------------------------------------------------
    assign fifo_full  = (cnt_q == CntW'(Outstanding));
    assign fifo_empty = (cnt_q == '0);
    assign push       = mem_ar_valid && mem_ar_ready;
    assign pop        = mem_r_valid && s_r_ready && mem_r_last && !fifo_empty;
    assign tail_ptr   = (wr_ptr_q == '0) ? PtrW'(Outstanding - 1) : wr_ptr_q - PtrW'(1);
    assign tail_id    = fifo_id_q[tail_ptr];
    assign head_flag  = !fifo_empty && fifo_flag_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Outstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Outstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            fifo_flag_q <= '0;
            for (int i = 0; i < int'(Outstanding); i++) begin
                fifo_id_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) begin
                fifo_flag_q[wr_ptr_q] <= last_sub;
                fifo_id_q[wr_ptr_q]   <= ar_id_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // AR FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rdy_en_q   <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            remain_q   <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (s_ar_valid && s_ar_ready) begin
                        ar_id_q    <= s_ar_id;
                        ar_addr_q  <= s_ar_addr;
                        ar_size_q  <= s_ar_size;
                        ar_burst_q <= s_ar_burst;
                        remain_q   <= {1'b0, s_ar_len} + 9'd1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (push) begin
                        ar_addr_q <= addr_d;
                        remain_q  <= remain_d;
                        if (last_sub) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // rdy_en_q keeps s_ar_ready low while in reset.
    assign s_ar_ready = rdy_en_q && (state_q == IDLE) && !fifo_full &&
                        (fifo_empty || (s_ar_id == tail_id));

    // Only our own push can fill the FIFO, so valid cannot drop before its
    // handshake once raised.
    assign mem_ar_valid = (state_q == ISSUE) && !fifo_full;
    assign mem_ar_id    = ar_id_q;
    assign mem_ar_addr  = ar_addr_q;
    assign mem_ar_len   = 8'(beats - 9'd1);
    assign mem_ar_size  = ar_size_q;
    assign mem_ar_burst = ar_burst_q;

    // ------------------------------------------------------------------
    // R pass-through
    // ------------------------------------------------------------------
    assign s_r_valid   = mem_r_valid;
    assign mem_r_ready = s_r_ready;
    assign s_r_id      = mem_r_id;
    assign s_r_data    = mem_r_data;
    assign s_r_resp    = mem_r_resp;
    assign s_r_last    = mem_r_last && head_flag;

endmodule
